// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency in-order memory responder; MEM_RESPONDER_RAND_STALL_EN adds LFSR ready stalls
module mem_responder #(
    parameter int Xlen           = 64,
    parameter int Depth          = 1024,
    parameter int Latency        = 2,
    parameter int MaxOutstanding = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [Xlen-1:0]   addr_i,
    input  logic [Xlen-1:0]   wdata_i,
    input  logic [Xlen/8-1:0] wmask_i,
    output logic [Xlen-1:0]   rdata_o,
    output logic              rvalid_o
);

    localparam int AW = $clog2(Depth);
    localparam int CW = $clog2(MaxOutstanding + 1);

    logic [Xlen-1:0] mem [Depth];
    logic [AW-1:0]   idx;
    logic            accept;
    logic            is_write;
    logic [Xlen-1:0] resp_data;
    logic            stall;
    logic [CW-1:0]   count;
    logic            dec;
    logic            unused_addr;

    logic            pv   [Latency];
    logic [Xlen-1:0] pd   [Latency];
    logic            in_v [Latency];
    logic [Xlen-1:0] in_d [Latency];

    assign idx         = addr_i[AW+2:3];
    assign unused_addr = ^{addr_i[Xlen-1:AW+3], addr_i[2:0]};
    assign accept      = valid_i && ready_o;
    assign is_write    = |wmask_i;
    assign resp_data   = is_write ? '0 : mem[idx];

    // Array deliberately has no reset so accepted writes survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (accept && is_write) begin
            for (int b = 0; b < Xlen / 8; b++) begin
                if (wmask_i[b]) begin
                    mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        in_v[0] = accept;
        in_d[0] = resp_data;
        for (int i = 1; i < Latency; i++) begin
            in_v[i] = pv[i-1];
            in_d[i] = pd[i-1];
        end
    end

    // Data only moves with a valid token, so the last stage holds rdata between pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Latency; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Latency; i++) begin
                pv[i] <= in_v[i];
                if (in_v[i]) begin
                    pd[i] <= in_d[i];
                end
            end
        end
    end

    assign rvalid_o = pv[Latency-1];
    assign rdata_o  = pd[Latency-1];

    // A request stops counting at the edge that raises its rvalid_o.
    assign dec = in_v[Latency-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (accept && !dec) begin
            count <= count + CW'(1);
        end else if (dec && !accept) begin
            count <= count - CW'(1);
        end
    end

`ifdef MEM_RESPONDER_RAND_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign ready_o = rst_ni && (count < CW'(MaxOutstanding)) && !stall;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [63:0] addr, wdata;
    logic [7:0]  wmask;
    logic        ready_d, rvalid_d, ready_t, rvalid_t, ready_m, rvalid_m;
    logic [63:0] rdata_d, rdata_t, rdata_m;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc;

    logic [63:0] q_d[$];
    int          qc_d[$];
    logic [63:0] q_t[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rvalid_d) begin
            q_d.push_back(rdata_d);
            qc_d.push_back(cyc);
        end
        if (rvalid_t) q_t.push_back(rdata_t);
    end

    mem_responder u_dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready_d),
        .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rdata_d), .rvalid_o(rvalid_d)
    );

    mem_responder #(.Latency(4), .MaxOutstanding(2)) u_thr (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready_t),
        .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rdata_t), .rvalid_o(rvalid_t)
    );

    mem_responder #(.Latency(4), .MaxOutstanding(4)) u_mid (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready_m),
        .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rdata_m), .rvalid_o(rvalid_m)
    );

    task automatic issue(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
        bit done = 1'b0;
        @(negedge clk);
        valid = 1'b1; addr = a; wdata = d; wmask = m;
        for (int i = 0; i < 50 && !done; i++) begin
            if (ready_d) begin
                @(posedge clk); #1;
                acc_cyc = cyc;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL issue_accept: accepted=0 required=1 addr=%h", a);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0; wmask = '0;
    endtask

    task automatic wait_resp(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (q_d.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bit ok;
        logic [63:0] d;
        q_d.delete(); qc_d.delete();
        issue(64'h40, 64'h0123456789ABCDEF, 8'hFF);
        idle();
        wait_resp(1, ok);
        q_d.delete(); qc_d.delete();
        @(negedge clk);
        rst_n = 1'b0; valid = 1'b1; addr = 64'h40; wdata = 64'hDEADBEEFDEADBEEF; wmask = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ready_d !== 1'b0 || rvalid_d !== 1'b0 || rdata_d !== 64'h0) begin
                errors++;
                $display("FAIL reset_outputs: ready=%b rvalid=%b rdata=%h required 0 0 0", ready_d, rvalid_d, rdata_d);
            end
            @(negedge clk);
        end
        rst_n = 1'b1; valid = 1'b0; wmask = '0;
        #1;
`ifndef MEM_RESPONDER_RAND_STALL_EN
        checks++;
        if (ready_d !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", ready_d);
        end
`endif
        issue(64'h40, 64'h0, 8'h00);
        idle();
        wait_resp(1, ok);
        checks++;
        d = ok ? q_d.pop_front() : 64'hx;
        if (d !== 64'h0123456789ABCDEF) begin
            errors++;
            $display("FAIL reset_array_kept: got %h required %h", d, 64'h0123456789ABCDEF);
        end
    endtask

    task automatic test_write_read();
        bit ok;
        logic [63:0] d;
        int c, a;
        q_d.delete(); qc_d.delete();
        issue(64'h10, 64'h1122334455667788, 8'hFF);
        a = acc_cyc;
        idle();
        wait_resp(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wr_write_resp: responses=0 required=1");
        end else begin
            d = q_d.pop_front(); c = qc_d.pop_front();
            if (d !== 64'h0 || c - a + 1 !== 2) begin
                errors++;
                $display("FAIL wr_write_resp: data=%h latency=%0d required 0 and 2", d, c - a + 1);
            end
        end
        issue(64'h10, 64'h0, 8'h00);
        a = acc_cyc;
        idle();
        wait_resp(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wr_read_resp: responses=0 required=1");
        end else begin
            d = q_d.pop_front(); c = qc_d.pop_front();
            if (d !== 64'h1122334455667788 || c - a + 1 !== 2) begin
                errors++;
                $display("FAIL wr_read_resp: data=%h latency=%0d required 1122334455667788 and 2", d, c - a + 1);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (rvalid_d !== 1'b0 || rdata_d !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL wr_pulse_hold: rvalid=%b rdata=%h required 0 1122334455667788", rvalid_d, rdata_d);
        end
    endtask

    task automatic test_byte_mask();
        bit ok;
        logic [63:0] d;
        logic [63:0] exp [4];
        exp[0] = 64'h0; exp[1] = 64'h0;
        exp[2] = 64'h00000000FFFFFFFF; exp[3] = 64'h00000000FFFFFFFF;
        q_d.delete(); qc_d.delete();
        issue(64'h18, 64'h0, 8'hFF);
        issue(64'h18, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        issue(64'h18, 64'h0, 8'h00);
        issue(64'h1C, 64'h0, 8'h00);
        idle();
        wait_resp(4, ok);
        for (int i = 0; i < 4; i++) begin
            checks++;
            d = (q_d.size() > 0) ? q_d.pop_front() : 64'hx;
            if (d !== exp[i]) begin
                errors++;
                $display("FAIL byte_mask_%0d: got %h required %h", i, d, exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [63:0] d;
        q_d.delete(); qc_d.delete();
        issue(64'h0, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
        issue(64'h2000, 64'h0, 8'h00);
        idle();
        wait_resp(2, ok);
        d = (q_d.size() > 0) ? q_d.pop_front() : 64'hx;
        d = (q_d.size() > 0) ? q_d.pop_front() : 64'hx;
        checks++;
        if (d !== 64'hAAAAAAAAAAAAAAAA) begin
            errors++;
            $display("FAIL wrap_read: got %h required %h", d, 64'hAAAAAAAAAAAAAAAA);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [63:0] d;
        int c;
        int acc [4];
        logic [63:0] exp [4];
        exp[0] = 64'h0; exp[1] = 64'h0123456789ABCDEF;
        exp[2] = 64'h0; exp[3] = 64'hFEDCBA9889ABCDEF;
        q_d.delete(); qc_d.delete();
        issue(64'h30, 64'h0123456789ABCDEF, 8'hFF); acc[0] = acc_cyc;
        issue(64'h30, 64'h0, 8'h00);                acc[1] = acc_cyc;
        issue(64'h30, 64'hFEDCBA9876543210, 8'hF0); acc[2] = acc_cyc;
        issue(64'h30, 64'h0, 8'h00);                acc[3] = acc_cyc;
        idle();
        wait_resp(4, ok);
        for (int i = 0; i < 4; i++) begin
            checks++;
            d = (q_d.size() > 0) ? q_d.pop_front() : 64'hx;
            c = (qc_d.size() > 0) ? qc_d.pop_front() : -100;
            if (d !== exp[i] || c - acc[i] + 1 !== 2) begin
                errors++;
                $display("FAIL b2b_%0d: data=%h latency=%0d required %h and 2", i, d, c - acc[i] + 1, exp[i]);
            end
        end
    endtask

    task automatic throttle_burst(input bit wr, output int n);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            valid = 1'b1; addr = 64'(8 * n); wdata = 64'(n); wmask = wr ? 8'hFF : 8'h00;
            #1;
`ifndef MEM_RESPONDER_RAND_STALL_EN
            checks++;
            if (ready_t !== ((c % 4) < 2)) begin
                errors++;
                $display("FAIL throttle_ready_c%0d: got %b required %b", c, ready_t, (c % 4) < 2);
            end
`endif
            if (ready_t) n++;
        end
        @(negedge clk);
        valid = 1'b0; wmask = '0;
        repeat (10) @(negedge clk);
        #1;
    endtask

    task automatic test_throttle();
        int n_w, n_r;
        repeat (8) @(negedge clk);
        q_t.delete();
        throttle_burst(1'b1, n_w);
        checks++;
        if (q_t.size() !== n_w) begin
            errors++;
            $display("FAIL throttle_write_count: got %0d required %0d", q_t.size(), n_w);
        end
`ifndef MEM_RESPONDER_RAND_STALL_EN
        checks++;
        if (n_w !== 6) begin
            errors++;
            $display("FAIL throttle_accepts: got %0d required 6", n_w);
        end
`endif
        foreach (q_t[i]) begin
            checks++;
            if (q_t[i] !== 64'h0) begin
                errors++;
                $display("FAIL throttle_write_data_%0d: got %h required 0", i, q_t[i]);
            end
        end
        q_t.delete();
        throttle_burst(1'b0, n_r);
        checks++;
        if (q_t.size() !== n_r) begin
            errors++;
            $display("FAIL throttle_read_count: got %0d required %0d", q_t.size(), n_r);
        end
        for (int j = 0; j < n_r && j < n_w && j < q_t.size(); j++) begin
            checks++;
            if (q_t[j] !== 64'(j)) begin
                errors++;
                $display("FAIL throttle_order_%0d: got %h required %h", j, q_t[j], 64'(j));
            end
        end
    endtask

    task automatic mid_req(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m,
                           output logic [63:0] rd, output int lat);
        bit done = 1'b0;
        int ac = 0;
        rd = 64'hx; lat = -1;
        @(negedge clk);
        valid = 1'b1; addr = a; wdata = d; wmask = m;
        for (int i = 0; i < 50 && !done; i++) begin
            if (ready_m) begin
                @(posedge clk); #1;
                ac = cyc;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        valid = 1'b0; wmask = '0;
        for (int i = 0; i < 20 && done; i++) begin
            if (rvalid_m) begin
                rd = rdata_m;
                lat = cyc - ac + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        int acc = 0, first = -1, seen = 0, lat;
        logic [63:0] rd;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid_m) seen++;
            if (acc == 3 || (first >= 0 && cyc - first >= 2)) break;
            valid = 1'b1; addr = 64'h100 + 64'(8 * acc); wmask = 8'h00;
            if (ready_m) begin
                @(posedge clk); #1;
                if (first < 0) first = cyc;
                acc++;
            end
        end
        rst_n = 1'b0; valid = 1'b0;
        #1;
        checks++;
        if (ready_m !== 1'b0 || rvalid_m !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: ready=%b rvalid=%b required 0 0", ready_m, rvalid_m);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rvalid_m) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mid_reset_stale: got %0d responses required 0", seen);
        end
`ifndef MEM_RESPONDER_RAND_STALL_EN
        checks++;
        if (acc !== 3) begin
            errors++;
            $display("FAIL mid_reset_accepts: got %0d required 3", acc);
        end
`endif
        mid_req(64'h100, 64'h5A5A0F0FC3C39696, 8'hFF, rd, lat);
        checks++;
        if (rd !== 64'h0 || lat !== 4) begin
            errors++;
            $display("FAIL mid_after_write: data=%h latency=%0d required 0 and 4", rd, lat);
        end
        mid_req(64'h100, 64'h0, 8'h00, rd, lat);
        checks++;
        if (rd !== 64'h5A5A0F0FC3C39696 || lat !== 4) begin
            errors++;
            $display("FAIL mid_after_read: data=%h latency=%0d required 5a5a0f0fc3c39696 and 4", rd, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; addr = '0; wdata = '0; wmask = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_write_read();
        test_byte_mask();
        test_wrap();
        test_back_to_back();
        test_throttle();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
